// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: assembles 16-bit instructions (plus an extension word
// for double-word opcodes) from a byte-wide memory and hands them to decode.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instruction,
  output logic [15:0] ext_word,
  output logic [15:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam logic [2:0] OP_I_TYPE = 3'd1;
  localparam logic [2:0] OP_M_TYPE = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [1:0]  bidx, bidx_nxt;
  logic        double_word;
  logic        accept;
  logic        redirect_take;
  logic        byte_we;
  logic        last_byte;

  // Byte 0 is already stored by the time the length decision is needed.
  assign double_word   = (instruction[2:0] == OP_I_TYPE) || (instruction[2:0] == OP_M_TYPE);
  assign accept        = (state == S_HOLD) && instr_ready;
  assign redirect_take = redirect_valid && (state != S_HALTED);
  assign byte_we       = (state == S_WAIT) && mem_rvalid && !redirect_valid && !halt;
  assign last_byte     = (bidx == 2'd3) || ((bidx == 2'd1) && !double_word);
  assign instr_pc      = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    bidx_nxt  = bidx;
    case (state)
      S_IDLE:   state_nxt = S_REQ;
      S_REQ:    state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          if (last_byte) begin
            state_nxt = S_HOLD;
          end else begin
            bidx_nxt  = bidx + 2'd1;
            state_nxt = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_nxt    = pc + (double_word ? 16'd4 : 16'd2);
          bidx_nxt  = 2'd0;
          state_nxt = S_REQ;
        end
      end
      S_DRAIN:  if (mem_rvalid) state_nxt = S_REQ;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase

    // A request strobed this cycle is in flight as well, so REQ drains like WAIT.
    if (redirect_take) begin
      pc_nxt   = redirect_pc;
      bidx_nxt = 2'd0;
      if ((state == S_REQ) || (((state == S_WAIT) || (state == S_DRAIN)) && !mem_rvalid))
        state_nxt = S_DRAIN;
      else
        state_nxt = S_REQ;
    end

    if (halt) state_nxt = S_HALTED;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      bidx        <= 2'd0;
      mem_req     <= 1'b0;
      mem_addr    <= 16'h0000;
      instr_valid <= 1'b0;
      instruction <= 16'h0000;
      ext_word    <= 16'h0000;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      bidx        <= bidx_nxt;
      mem_req     <= (state_nxt == S_REQ);
      instr_valid <= (state_nxt == S_HOLD);
      halted      <= (state_nxt == S_HALTED);
      if (state_nxt == S_REQ) mem_addr <= pc_nxt + {14'b0, bidx_nxt};

      if (byte_we) begin
        case (bidx)
          2'd0:    instruction[7:0]  <= mem_rdata;
          2'd1:    instruction[15:8] <= mem_rdata;
          2'd2:    ext_word[7:0]     <= mem_rdata;
          default: ext_word[15:8]    <= mem_rdata;
        endcase
      end else if (accept || redirect_take) begin
        ext_word <= 16'h0000;
      end
    end
  end

endmodule
